ofdm_cp_remover: RTL and testbench
==================================

Name: ofdm_cp_remover

Overview:
RX-side stage directly downstream of the OFDM ADC capture (14-bit real/imag sample stream).
- Aligns to a symbol-start strobe from the timing-sync logic.
- Discards the CP_LEN cyclic-prefix samples and forwards the N_FFT useful samples, framed with sop/eop, to the FFT input over a valid/ready interface.
- Buffers in a FIFO because the ADC side cannot be stalled; only whole symbols are ever queued.

Parameters:
DATA_W, 14, sample width per I/Q component (two's complement)
N_FFT, 64, useful samples per symbol
CP_LEN, 16, cyclic-prefix samples per symbol (1..N_FFT)
FIFO_DEPTH, 128, output FIFO entries, power of 2, must be >= N_FFT

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  ADC sample valid; no backpressure
in_real  in  DATA_W  ADC real sample
in_imag  in  DATA_W  ADC imag sample
sym_start  in  1  qualified by in_valid; marks first CP sample of a symbol
out_valid  out  1  FIFO head valid
out_ready  in  1  FFT accepts head when out_valid&out_ready
out_real  out  DATA_W  useful sample real
out_imag  out  DATA_W  useful sample imag
out_sop  out  1  first useful sample of symbol
out_eop  out  1  N_FFT-th useful sample of symbol
sync_err  out  1  1-cycle pulse: sym_start at an unexpected position
overflow  out  1  sticky: a symbol was dropped for lack of FIFO space

Behaviour:
- Reset: state=IDLE, counters 0, FIFO empty; out_valid=0, out_sop=0, out_eop=0, out_real/out_imag=0, sync_err=0, overflow=0. Reset mid-symbol discards FIFO contents and any partial symbol.
- All state updates occur only on cycles with in_valid=1, except FIFO reads.
- IDLE: ignore samples until sym_start=1. That sample is CP sample 0: cnt<=1, go SKIP_CP (or go directly to the entry check if CP_LEN=1).
- SKIP_CP: discard samples. When the sample with cnt==CP_LEN-1 arrives, perform the entry check:
  - If FIFO free entries >= N_FFT: go PASS.
  - Otherwise: go DROP and set overflow<=1.
  - In both cases cnt<=0.
- SKIP_CP resync: sym_start=1 on a sample with cnt!=0 restarts the count (that sample becomes CP sample 0) and pulses sync_err.
- PASS: write {sop=(cnt==0), eop=(cnt==N_FFT-1), real, imag} to the FIFO. After cnt==N_FFT-1, go SKIP_CP with cnt<=0; symbols are assumed back-to-back.
- PASS resync: sym_start in PASS is ignored for framing and pulses sync_err.
- DROP: identical counting to PASS, no FIFO writes; then SKIP_CP. sym_start in DROP behaves as in PASS.
- Expected boundary: sym_start on the first SKIP_CP sample (cnt==0) after PASS/DROP is normal; no sync_err.
- FIFO write can never hit full, because space is reserved at PASS entry. Simultaneous read and write on the same cycle are allowed, including when the FIFO is empty→1 or full.
- Latency: a PASS sample accepted at edge k is presented (out_valid=1) in cycle k+1 when the FIFO was empty. Outputs hold stable while out_valid&!out_ready.
- No arithmetic is performed; samples pass bit-exact. Counter width is $clog2(max(N_FFT,CP_LEN)).

Optional Feature:
Macro: CP_REMOVE_STATS_EN.
- Defined: adds outputs sym_count[15:0] (+1 per symbol written to FIFO) and drop_count[15:0] (+1 per DROP entry). Both saturate at 16'hFFFF and are reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package ofdm_rx_pkg: DATA_W default, N_FFT and CP_LEN defaults, state enum {IDLE, SKIP_CP, PASS, DROP}, FIFO entry struct {sop, eop, real, imag}.
- One sub-module: ofdm_sample_fifo, a synchronous first-word-fall-through FIFO. Width 2*DATA_W+2, depth FIFO_DEPTH, with a free-count output.

Test Plan:
- Reset, then sym_start plus 80 continuous samples with ramp values 0..79, out_ready=1 → 64 outputs with values 16..79; sop on 16, eop on 79; first out_valid one cycle after sample 16; sync_err=0.
- 3 back-to-back symbols (240 samples), sym_start on samples 0/80/160 → 192 outputs with correct sop/eop; no sync_err.
- out_ready=0 throughout, 3 symbols, FIFO_DEPTH=128 → symbols 1 and 2 queued (128 entries); symbol 3 dropped; overflow=1. Releasing out_ready then yields exactly 128 samples.
- sym_start on CP sample 5 of symbol 2 → sync_err pulse; symbol 2 useful data starts 16 samples after the resync sample.
- sym_start during PASS sample 30 → sync_err pulse; symbol completes unchanged (64 samples, eop intact).
- Assert reset while PASS is at sample 40 with 20 samples in FIFO → next cycle out_valid=0, FIFO empty, state IDLE; later samples are ignored until the next sym_start.

Source files
------------

// File: rtl/ofdm_rx_pkg.sv
// Shared defaults and types for the OFDM RX cyclic-prefix removal path.
package ofdm_rx_pkg;

    localparam int DATA_W_DEF = 14;
    localparam int N_FFT_DEF  = 64;
    localparam int CP_LEN_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        SKIP_CP,
        PASS,
        DROP
    } cp_state_t;

    // Default-width FIFO entry; the top re-declares it at its own DATA_W.
    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [DATA_W_DEF-1:0] re;
        logic [DATA_W_DEF-1:0] im;
    } fifo_entry_t;

endpackage

// File: rtl/ofdm_sample_fifo.sv
// Synchronous first-word-fall-through FIFO with a free-entry count.
// Head data reads as zero while empty.
module ofdm_sample_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 128
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    output logic                      rd_valid,
    output logic [WIDTH-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]    free
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_rd;
    logic             do_wr;

    assign do_rd = rd_en && (count != '0);
    // A write while full is only legal when the head is consumed on the same edge.
    assign do_wr = wr_en && ((count != (AW+1)'(DEPTH)) || do_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign free     = (AW+1)'(DEPTH) - count;

endmodule

// File: rtl/ofdm_cp_remover.sv
// Strips the cyclic prefix from each OFDM symbol and queues whole useful symbols
// for the FFT. Define CP_REMOVE_STATS_EN to add sym_count/drop_count outputs.
module ofdm_cp_remover
    import ofdm_rx_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int N_FFT      = N_FFT_DEF,
    parameter int CP_LEN     = CP_LEN_DEF,
    parameter int FIFO_DEPTH = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    input  logic              sym_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic              out_sop,
    output logic              out_eop,
    output logic              sync_err,
    output logic              overflow
`ifdef CP_REMOVE_STATS_EN
    ,
    output logic [15:0]       sym_count,
    output logic [15:0]       drop_count
`endif
);

    localparam int MAXC  = (N_FFT > CP_LEN) ? N_FFT : CP_LEN;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int FW    = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } entry_t;

    cp_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             err_n;
    logic             ovf_set;
    logic             entry_chk;
    logic             wr_en;
    logic             last_useful;
    entry_t           wr_entry;
    entry_t           rd_entry;
    logic [FW:0]      free;

    assign last_useful = (cnt == CNT_W'(N_FFT - 1));

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        err_n     = 1'b0;
        ovf_set   = 1'b0;
        entry_chk = 1'b0;
        wr_en     = 1'b0;
        wr_entry  = '0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    if (sym_start) begin
                        if (CP_LEN == 1) begin
                            entry_chk = 1'b1;
                        end else begin
                            cnt_n   = CNT_W'(1);
                            state_n = SKIP_CP;
                        end
                    end
                end
                SKIP_CP: begin
                    // cnt is always 0 here when CP_LEN==1, so resync implies CP_LEN>1
                    if (sym_start && (cnt != '0)) begin
                        err_n = 1'b1;
                        cnt_n = CNT_W'(1);
                    end else if (cnt == CNT_W'(CP_LEN - 1)) begin
                        entry_chk = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                PASS, DROP: begin
                    wr_en        = (state == PASS);
                    wr_entry.sop = (cnt == '0);
                    wr_entry.eop = last_useful;
                    wr_entry.re  = in_real;
                    wr_entry.im  = in_imag;
                    err_n        = sym_start;
                    if (last_useful) begin
                        state_n = SKIP_CP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
            // Space for the whole symbol is reserved here, so PASS writes never see a full FIFO.
            if (entry_chk) begin
                cnt_n = '0;
                if (free >= (FW+1)'(N_FFT)) begin
                    state_n = PASS;
                end else begin
                    state_n = DROP;
                    ovf_set = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sync_err <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sync_err <= err_n;
            if (ovf_set) overflow <= 1'b1;
        end
    end

    ofdm_sample_fifo #(
        .WIDTH (2*DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_entry),
        .rd_en    (out_ready),
        .rd_valid (out_valid),
        .rd_data  (rd_entry),
        .free     (free)
    );

    assign out_sop  = rd_entry.sop;
    assign out_eop  = rd_entry.eop;
    assign out_real = rd_entry.re;
    assign out_imag = rd_entry.im;

`ifdef CP_REMOVE_STATS_EN
    logic sym_done;
    assign sym_done = in_valid && (state == PASS) && last_useful;

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_count  <= '0;
            drop_count <= '0;
        end else begin
            if (sym_done && (sym_count != '1)) sym_count <= sym_count + 1'b1;
            if (ovf_set && (drop_count != '1)) drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Self-checking bench for ofdm_cp_remover: randomized sample streams checked
// against a symbol-offset reference model of CP removal.
module tb_ofdm_cp_remover;

    localparam int DW    = 14;
    localparam int NF    = 64;
    localparam int CP    = 16;
    localparam int DEPTH = 128;
    localparam int SYM   = CP + NF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          sym_start = 1'b0;
    logic [DW-1:0] in_real = '0;
    logic [DW-1:0] in_imag = '0;
    logic          out_ready = 1'b1;
    logic          out_valid, out_sop, out_eop, sync_err, overflow;
    logic [DW-1:0] out_real, out_imag;
`ifdef CP_REMOVE_STATS_EN
    logic [15:0]   sym_count, drop_count;
`endif

    always #5 clk = ~clk;

    ofdm_cp_remover #(
        .DATA_W     (DW),
        .N_FFT      (NF),
        .CP_LEN     (CP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .sym_start  (sym_start),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .sync_err   (sync_err),
        .overflow   (overflow)
`ifdef CP_REMOVE_STATS_EN
        ,
        .sym_count  (sym_count),
        .drop_count (drop_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [2*DW+1:0] exp_q[$];
    logic [2*DW+1:0] got_q[$];
    int  exp_err = 0;
    int  got_err = 0;
    bit  rnd_ready = 0;

    // Reference model: position within the current symbol (0..SYM-1), symbols back-to-back.
    bit  m_active = 0;
    int  m_off = 0;
    bit  m_track = 0;
    int  m_occ = 0;
    bit  m_dropping = 0;

    function automatic void model_reset();
        m_active   = 0;
        m_off      = 0;
        m_occ      = 0;
        m_dropping = 0;
        exp_q.delete();
    endfunction

    function automatic void model_step(input logic ss, input logic [DW-1:0] r, input logic [DW-1:0] i);
        if (!m_active) begin
            if (!ss) return;
            m_active = 1;
            m_off    = 0;
        end else begin
            m_off = (m_off + 1) % SYM;
            if (ss) begin
                if (m_off >= CP) exp_err++;
                else if (m_off != 0) begin
                    exp_err++;
                    m_off = 0;
                end
            end
        end
        if (m_off == CP) m_dropping = m_track && (m_occ + NF > DEPTH);
        if (m_off >= CP && !m_dropping) begin
            exp_q.push_back({m_off == CP, m_off == SYM - 1, r, i});
            m_occ++;
        end
    endfunction

    function automatic logic [DW-1:0] rnd();
        return DW'($urandom);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) got_q.push_back({out_sop, out_eop, out_real, out_imag});
            if (sync_err) got_err++;
        end
    end

    task automatic drive(input logic v, input logic ss, input logic [DW-1:0] r, input logic [DW-1:0] i);
        in_valid  = v;
        sym_start = ss;
        in_real   = r;
        in_imag   = i;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        if (v) model_step(ss, r, i);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        sym_start = 1'b0;
    endtask

    task automatic wait_drain(output bit timed_out);
        timed_out = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            if (got_q.size() >= exp_q.size() && !out_valid) begin
                timed_out = 0;
                break;
            end
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_scoreboard();
        exp_q.delete();
        got_q.delete();
        exp_err = 0;
        got_err = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid/sop/eop=%b%b%b, required 000", out_valid, out_sop, out_eop);
        end
        checks++;
        if (out_real !== '0 || out_imag !== '0) begin
            errors++;
            $display("FAIL reset_data: real=%0h imag=%0h, required 0 0", out_real, out_imag);
        end
        checks++;
        if (sync_err !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: sync_err=%b overflow=%b, required 0 0", sync_err, overflow);
        end
        reset = 1'b0;
        model_reset();
        clear_scoreboard();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_symbol();
        bit to;
        clear_scoreboard();
        out_ready = 1'b1;
        for (int k = 0; k < SYM; k++) begin
            drive(1'b1, k == 0, DW'(k), DW'(k + 1000));
            if (k == CP - 1) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL single_early_valid: out_valid=%b after last CP sample, required 0", out_valid);
                end
            end
            if (k == CP) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_real !== DW'(CP)) begin
                    errors++;
                    $display("FAIL single_latency: valid=%b sop=%b real=%0d, required 1 1 %0d",
                             out_valid, out_sop, out_real, CP);
                end
            end
        end
        wait_drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL single_drain: timeout with %0d of %0d outputs", got_q.size(), exp_q.size()); end
        checks++;
        if (got_q.size() !== NF) begin errors++; $display("FAIL single_count: got %0d outputs, required %0d", got_q.size(), NF); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL single_data[%0d]: got %h, required %h", k, got_q[k], exp_q[k]); end
        end
        if (got_q.size() == NF) begin
            checks++;
            if (got_q[NF-1] !== {1'b0, 1'b1, DW'(SYM - 1), DW'(SYM - 1 + 1000)}) begin
                errors++;
                $display("FAIL single_eop: got %h, required eop with value %0d", got_q[NF-1], SYM - 1);
            end
        end
        checks++;
        if (got_err !== 0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL single_flags: sync_err pulses=%0d overflow=%b, required 0 0", got_err, overflow);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int nsop, neop;
        clear_scoreboard();
        rnd_ready = 1;
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < SYM; j++) begin
                repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom_range(0, 1)), rnd(), rnd());
                drive(1'b1, j == 0, rnd(), rnd());
            end
        end
        wait_drain(to);
        rnd_ready = 0;
        nsop = 0;
        neop = 0;
        foreach (got_q[k]) begin
            if (got_q[k][2*DW+1]) nsop++;
            if (got_q[k][2*DW]) neop++;
        end
        checks++;
        if (to) begin errors++; $display("FAIL b2b_drain: timeout with %0d of %0d outputs", got_q.size(), exp_q.size()); end
        checks++;
        if (got_q.size() !== 3*NF) begin errors++; $display("FAIL b2b_count: got %0d outputs, required %0d", got_q.size(), 3*NF); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_data[%0d]: got %h, required %h", k, got_q[k], exp_q[k]); end
        end
        checks++;
        if (nsop !== 3 || neop !== 3) begin errors++; $display("FAIL b2b_framing: sop=%0d eop=%0d, required 3 3", nsop, neop); end
        checks++;
        if (got_err !== 0) begin errors++; $display("FAIL b2b_sync_err: %0d pulses, required 0", got_err); end
    endtask

    task automatic test_cp_resync();
        bit to;
        int v, rs, nsop, sop2;
        clear_scoreboard();
        out_ready = 1'b1;
        v  = 0;
        rs = 0;
        for (int j = 0; j < SYM; j++) begin drive(1'b1, j == 0, DW'(v), rnd()); v++; end
        for (int j = 0; j < 5; j++) begin drive(1'b1, j == 0, DW'(v), rnd()); v++; end
        rs = v;
        for (int j = 0; j < SYM; j++) begin drive(1'b1, j == 0, DW'(v), rnd()); v++; end
        wait_drain(to);
        nsop = 0;
        sop2 = 0;
        foreach (got_q[k]) if (got_q[k][2*DW+1]) begin nsop++; if (nsop == 2) sop2 = k; end
        checks++;
        if (to) begin errors++; $display("FAIL cpres_drain: timeout with %0d of %0d outputs", got_q.size(), exp_q.size()); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL cpres_count: got %0d outputs, required %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL cpres_data[%0d]: got %h, required %h", k, got_q[k], exp_q[k]); end
        end
        checks++;
        if (nsop !== 2 || got_q[sop2][2*DW-1:DW] !== DW'(rs + CP)) begin
            errors++;
            $display("FAIL cpres_sop: %0d sops, second at value %0d, required 2 sops, value %0d",
                     nsop, got_q[sop2][2*DW-1:DW], rs + CP);
        end
        checks++;
        if (got_err !== 1 || got_err !== exp_err) begin errors++; $display("FAIL cpres_sync_err: %0d pulses, required 1", got_err); end
    endtask

    task automatic test_pass_resync();
        bit to;
        clear_scoreboard();
        out_ready = 1'b1;
        for (int j = 0; j < SYM; j++) drive(1'b1, (j == 0) || (j == CP + 30), rnd(), rnd());
        wait_drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL passres_drain: timeout with %0d of %0d outputs", got_q.size(), exp_q.size()); end
        checks++;
        if (got_q.size() !== NF) begin errors++; $display("FAIL passres_count: got %0d outputs, required %0d", got_q.size(), NF); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL passres_data[%0d]: got %h, required %h", k, got_q[k], exp_q[k]); end
        end
        if (got_q.size() == NF) begin
            checks++;
            if (got_q[NF-1][2*DW] !== 1'b1) begin errors++; $display("FAIL passres_eop: last eop=%b, required 1", got_q[NF-1][2*DW]); end
        end
        checks++;
        if (got_err !== 1 || got_err !== exp_err) begin errors++; $display("FAIL passres_sync_err: %0d pulses, required 1", got_err); end
    endtask

    task automatic test_backpressure_overflow();
        bit to;
        logic [2*DW+1:0] head;
        clear_scoreboard();
        out_ready = 1'b0;
        m_track   = 1;
        m_occ     = 0;
        for (int j = 0; j < 3*SYM; j++) drive(1'b1, (j % SYM) == 0, rnd(), rnd());
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: overflow=%b, required 1", overflow); end
        checks++;
        if (got_q.size() !== 0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: %0d outputs taken, out_valid=%b, required 0 taken, valid 1", got_q.size(), out_valid);
        end
        head = {out_sop, out_eop, out_real, out_imag};
        repeat (4) @(negedge clk);
        checks++;
        if ({out_sop, out_eop, out_real, out_imag} !== head || head !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_hold: head %h then %h, required %h",
                     head, {out_sop, out_eop, out_real, out_imag}, exp_q[0]);
        end
        out_ready = 1'b1;
        wait_drain(to);
        m_track = 0;
        checks++;
        if (to) begin errors++; $display("FAIL bp_drain: timeout with %0d of %0d outputs", got_q.size(), exp_q.size()); end
        checks++;
        if (got_q.size() !== DEPTH) begin errors++; $display("FAIL bp_count: got %0d outputs, required %0d", got_q.size(), DEPTH); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL bp_data[%0d]: got %h, required %h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_reset_mid_symbol();
        bit to;
        clear_scoreboard();
        out_ready = 1'b0;
        for (int j = 0; j < CP + 40; j++) drive(1'b1, j == 0, rnd(), rnd());
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: valid=%b overflow=%b sync_err=%b, required 0 0 0", out_valid, overflow, sync_err);
        end
        reset = 1'b0;
        model_reset();
        clear_scoreboard();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 0; j < 30; j++) drive(1'b1, 1'b0, rnd(), rnd());
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() !== 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: %0d outputs, valid=%b, required 0 0", got_q.size(), out_valid);
        end
        for (int j = 0; j < SYM; j++) drive(1'b1, j == 0, rnd(), rnd());
        wait_drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL midrst_drain: timeout with %0d of %0d outputs", got_q.size(), exp_q.size()); end
        checks++;
        if (got_q.size() !== NF) begin errors++; $display("FAIL midrst_count: got %0d outputs, required %0d", got_q.size(), NF); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL midrst_data[%0d]: got %h, required %h", k, got_q[k], exp_q[k]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_symbol();
        test_back_to_back();
        test_cp_resync();
        test_pass_resync();
        test_backpressure_overflow();
        test_reset_mid_symbol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
